// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions for the TX scheduler and RX path.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_MAC,
    ST_SIZE,
    ST_DATA,
    ST_GAP
  } eth_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam int         MAC_BYTES     = 6;
  localparam int         HDR_BYTES     = 7;   // MAC bytes plus the size byte

  // Byte idx of a MAC address, LSB byte first on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    return mac[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module eth_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  logic found;
  int   cand;

  // Scan requests starting at ptr, wrapping once around the vector.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin TX scheduler: grants one requester the byte link and sequences
// preamble, destination MAC, size byte, payload and inter-frame gap.
module eth_tx_scheduler
  import eth_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int PBLE_LEN   = 8,
  parameter int IFG_CYCLES = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [48*NREQ-1:0] req_mac,
  input  logic [8*NREQ-1:0]  req_len,
  input  logic [8*NREQ-1:0]  pl_data,
  input  logic               abort,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    pl_pop,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               busy,
  output logic [NREQ-1:0]    frame_done,
  output logic [NREQ-1:0]    aborted
);

  localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              GW        = $clog2(IFG_CYCLES + 1);
  localparam logic [7:0]      PBLE_LAST = 8'(PBLE_LEN - 1);
  localparam logic [7:0]      MAC_LAST  = 8'(MAC_BYTES - 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(IFG_CYCLES - 1);

  eth_state_e      state_q;
  logic [IW-1:0]   ptr_q, owner_q;
  logic [47:0]     mac_q;
  logic [7:0]      len_q, cnt_q;
  logic [GW-1:0]   gap_q;
  logic [NREQ-1:0] grant_q, done_q, aborted_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx, ptr_d;
  logic            arb_valid;
  logic [47:0]     sel_mac;
  logic [7:0]      sel_len, pl_byte;
  logic            in_frame, abort_hit, frame_end, load_pl;

  eth_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign ptr_d   = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
  assign sel_mac = req_mac[48*int'(arb_idx) +: 48];
  assign sel_len = req_len[8*int'(arb_idx) +: 8];
  assign pl_byte = pl_data[8*int'(owner_q) +: 8];

  assign in_frame  = (state_q == ST_PREAMBLE) || (state_q == ST_MAC) ||
                     (state_q == ST_SIZE)     || (state_q == ST_DATA);
  assign abort_hit = abort && in_frame;
  assign frame_end = ((state_q == ST_SIZE) && (len_q == 8'd0)) ||
                     ((state_q == ST_DATA) && (cnt_q == len_q - 8'd1));
  // A payload byte is captured into the TX register at the next edge; the
  // pop travels with that capture so the show-ahead source advances in step.
  assign load_pl   = ((state_q == ST_SIZE) && (len_q != 8'd0)) ||
                     ((state_q == ST_DATA) && !frame_end);

  assign pl_pop     = (load_pl && !abort_hit) ? grant_q : '0;
  assign grant      = grant_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign aborted    = aborted_q;

  // Frame sequencer with registered link outputs; abort overrides the step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      mac_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      aborted_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values; later assignments below win.
      done_q    <= '0;
      aborted_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            owner_q    <= arb_idx;
            mac_q      <= sel_mac;
            len_q      <= sel_len;
            ptr_q      <= ptr_d;
            grant_q    <= arb_gnt;
            tx_data_q  <= PREAMBLE_BYTE;
            tx_valid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          if (cnt_q == PBLE_LAST) begin
            cnt_q     <= '0;
            tx_data_q <= mac_byte(mac_q, 3'd0);
            state_q   <= ST_MAC;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_MAC: begin
          if (cnt_q == MAC_LAST) begin
            tx_data_q <= len_q;
            state_q   <= ST_SIZE;
          end else begin
            tx_data_q <= mac_byte(mac_q, 3'(cnt_q + 8'd1));
            cnt_q     <= cnt_q + 8'd1;
          end
        end
        ST_SIZE: begin
          if (len_q != 8'd0) begin
            tx_data_q <= pl_byte;
            cnt_q     <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!frame_end) begin
            tx_data_q <= pl_byte;
            cnt_q     <= cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_q <= ST_IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (frame_end || abort_hit) begin
        state_q    <= ST_GAP;
        gap_q      <= '0;
        grant_q    <= '0;
        tx_data_q  <= '0;
        tx_valid_q <= 1'b0;
        done_q     <= abort_hit ? '0 : grant_q;
        aborted_q  <= abort_hit ? grant_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed self-checking bench for eth_tx_scheduler (NREQ=4, PBLE_LEN=8, IFG=12).
module tb_eth_tx_scheduler;

  localparam int NREQ = 4;
  localparam int PBLE = 8;
  localparam int HDR  = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [48*NREQ-1:0] req_mac;
  logic [8*NREQ-1:0]  req_len;
  logic [8*NREQ-1:0]  pl_data;
  logic               abort;
  logic [NREQ-1:0]    grant, pl_pop, frame_done, aborted;
  logic [7:0]         tx_data;
  logic               tx_valid, busy;

  int n_pass  = 0;
  int n_total = 0;

  // Payload source model: show-ahead byte array per requester.
  logic [7:0]  src_mem [NREQ][32];
  int          rd_ptr    [NREQ];
  int          pop_total [NREQ];
  int          exp_ptr   [NREQ];
  logic [47:0] mac_tab   [NREQ];

  eth_tx_scheduler #(.NREQ(4), .PBLE_LEN(8), .IFG_CYCLES(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_mac    (req_mac),
    .req_len    (req_len),
    .pl_data    (pl_data),
    .abort      (abort),
    .grant      (grant),
    .pl_pop     (pl_pop),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  always_comb begin
    pl_data = '0;
    for (int i = 0; i < NREQ; i++) pl_data[8*i +: 8] = src_mem[i][rd_ptr[i] % 32];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (pl_pop[i]) begin
        rd_ptr[i]    <= rd_ptr[i] + 1;
        pop_total[i] <= pop_total[i] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] oh(input int idx);
    return 4'(1 << idx);
  endfunction

  task automatic wait_first(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_valid && n < max_cycles);
    check("frame_start", 64'(tx_valid), 64'd1);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("reach_idle", 64'(busy), 64'd0);
  endtask

  // Called in the cycle showing the first preamble byte; returns in the first gap cycle.
  task automatic expect_frame(input int owner, input logic [47:0] mac, input logic [7:0] len);
    logic [7:0] exp;
    int base;
    int flen;
    base = pop_total[owner];
    flen = PBLE + HDR + int'(len);
    check("grant_owner", 64'(grant), 64'(oh(owner)));
    for (int k = 0; k < flen; k++) begin
      if (k < PBLE)            exp = 8'hAA;
      else if (k < PBLE + 6)   exp = mac[8*(k-PBLE) +: 8];
      else if (k == PBLE + 6)  exp = len;
      else                     exp = src_mem[owner][(exp_ptr[owner] + k - PBLE - HDR) % 32];
      check($sformatf("tx_byte_r%0d_k%0d", owner, k), 64'({tx_valid, tx_data}), 64'({1'b1, exp}));
      tick();
    end
    check("done_pulse",   64'(frame_done), 64'(oh(owner)));
    check("gap_no_valid", 64'({tx_valid, grant, aborted}), 64'd0);
    check("pop_count",    64'(pop_total[owner] - base), 64'(len));
    exp_ptr[owner] += int'(len);
  endtask

  initial begin
    int n;
    logic [7:0] vec1 [17];

    for (int i = 0; i < NREQ; i++) begin
      rd_ptr[i] = 0; pop_total[i] = 0; exp_ptr[i] = 0;
      for (int j = 0; j < 32; j++) src_mem[i][j] = 8'(16*i + j + 1);
    end
    src_mem[0][0] = 8'hAB;
    src_mem[0][1] = 8'hCD;
    mac_tab[0] = 48'h4A6F8A7FAA8F;
    mac_tab[1] = 48'h112233445566;
    mac_tab[2] = 48'hA1B2C3D4E5F6;
    mac_tab[3] = 48'h0F1E2D3C4B5A;
    vec1 = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
             8'h8F, 8'hAA, 8'h7F, 8'h8A, 8'h6F, 8'h4A, 8'h02, 8'hAB, 8'hCD};

    rst = 1'b1; req = '0; abort = 1'b0; req_len = '0;
    for (int i = 0; i < NREQ; i++) req_mac[48*i +: 48] = mac_tab[i];
    tick();
    tick();
    check("reset_outputs", 64'({grant, pl_pop, frame_done, aborted, tx_valid, busy, tx_data}), 64'd0);

    // Single frame from requester 0 with hand-computed bytes.
    rst = 1'b0;
    req = 4'b0001;
    req_len[7:0] = 8'd2;
    tick();
    check("t1_grant", 64'(grant), 64'h1);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("t1_byte_%0d", k), 64'({tx_valid, tx_data}), 64'({1'b1, vec1[k]}));
      tick();
    end
    check("t1_done_c18", 64'({frame_done, tx_valid, grant, busy}), 64'({4'b0001, 1'b0, 4'b0000, 1'b1}));
    req = '0;
    for (int k = 0; k < 11; k++) tick();
    check("t1_busy_c29", 64'(busy), 64'd1);
    tick();
    check("t1_idle_c30", 64'(busy), 64'd0);
    check("t1_pops", 64'(pop_total[0]), 64'd2);
    exp_ptr[0] = 2;

    // All four requesting: RR order 0,1,2,3,0 after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_len[8*i +: 8] = 8'd1;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_first(40, n);
      check($sformatf("rr_latency_%0d", f), 64'(n), (f == 0) ? 64'd1 : 64'd13);
      expect_frame(f % 4, mac_tab[f % 4], 8'd1);
    end
    req = '0;

    // Zero-length payload on requester 2.
    req_len[23:16] = 8'd0;
    req = 4'b0100;
    wait_first(40, n);
    expect_frame(2, mac_tab[2], 8'd0);
    req = '0;

    // Abort while idle is ignored.
    wait_idle(40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_ignored", 64'({busy, aborted, tx_valid}), 64'd0);

    // Abort during the 3rd MAC byte of requester 3; requester 1 follows.
    req_len[15:8]  = 8'd3;
    req_len[31:24] = 8'd2;
    req = 4'b1010;
    wait_first(40, n);
    check("ab_grant", 64'(grant), 64'h8);
    for (int k = 0; k < PBLE + 2; k++) tick();
    check("ab_mac3", 64'({tx_valid, tx_data}), 64'({1'b1, mac_tab[3][23:16]}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_pulse", 64'({aborted, frame_done, grant, tx_valid, busy}),
          64'({4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1}));
    req = 4'b0010;
    wait_first(40, n);
    check("ab_next_latency", 64'(n), 64'd13);
    expect_frame(1, mac_tab[1], 8'd3);
    req = '0;

    // Reset during DATA, then req[1] and req[0] together -> 0 first.
    req_len[31:24] = 8'd4;
    req = 4'b1000;
    wait_first(40, n);
    for (int k = 0; k < PBLE + HDR + 1; k++) tick();
    check("rs_in_data", 64'({tx_valid, grant}), 64'({1'b1, 4'b1000}));
    rst = 1'b1;
    tick();
    check("rs_outputs", 64'({grant, pl_pop, frame_done, aborted, tx_valid, busy, tx_data}), 64'd0);
    rst = 1'b0;
    req_len[7:0]  = 8'd2;
    req_len[15:8] = 8'd1;
    req = 4'b0011;
    wait_first(10, n);
    check("rs_latency", 64'(n), 64'd1);
    expect_frame(0, mac_tab[0], 8'd2);
    req = 4'b0010;
    wait_first(40, n);
    expect_frame(1, mac_tab[1], 8'd1);
    req = '0;

    // Length and MAC changes after grant are ignored.
    req_len[23:16] = 8'd3;
    req = 4'b0100;
    wait_first(40, n);
    req_len[23:16]  = 8'd5;
    req_mac[143:96] = 48'hFFEEDDCCBBAA;
    expect_frame(2, mac_tab[2], 8'd3);
    req = '0;
    wait_idle(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
